// File: rtl/nes_vram_arbiter.sv
// nes_vram_arbiter: round-robin arbiter sharing one single-port nametable VRAM among NCH requesters
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   mirror   00 horizontal, 01 vertical, 10 single lower, 11 single upper
//   req/we/addr/wdata  per-channel request, write enable, logical address, write data
//   gnt      one-cycle pulse per accepted access
//   rvalid   one-cycle pulse when rdata holds that channel's read result
//   rdata    shared read-data bus
//   NES_MIRROR_EN defined: mirroring driven by mirror; undefined: linear phys = L[AW-1:0]
module nes_vram_arbiter #(
    parameter int NCH = 2,
    parameter int AW  = 11,
    parameter int DW  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            mirror,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [NCH*(AW+1)-1:0] addr,
    input  logic [NCH*DW-1:0]     wdata,
    output logic [NCH-1:0]        gnt,
    output logic [NCH-1:0]        rvalid,
    output logic [DW-1:0]         rdata
);
    localparam int PW = NCH > 1 ? $clog2(NCH) : 1;

    logic [PW-1:0] ptr, win, rd_ch;
    logic          found, go, rd_pend;
    logic [AW:0]   la_a [NCH];
    logic [DW-1:0] wd_a [NCH];
    logic [AW:0]   la;
    logic [AW-1:0] phys;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] mem_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign la_a[i] = addr[i*(AW+1) +: AW+1];
        assign wd_a[i] = wdata[i*DW +: DW];
    end

    // Scan from the highest offset down so the closest requester at/after ptr wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[PW'((int'(ptr) + k) % NCH)]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % NCH);
            end
        end
    end

    assign la = la_a[win];
    // No access is performed on an edge where reset is held.
    assign go = found & reset_n;

`ifdef NES_MIRROR_EN
    always_comb
        phys = mirror[1] ? {mirror[0], la[AW-2:0]}
                         : {mirror[0] ? la[AW-1] : la[AW], la[AW-2:0]};
`else
    logic unused_mirror;
    assign phys          = la[AW-1:0];
    assign unused_mirror = ^{mirror, la[AW]};
`endif

    always_ff @(posedge clk) begin
        if (go) begin
            if (we[win])
                mem[phys] <= wd_a[win];
            else
                mem_q <= mem[phys];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            gnt     <= '0;
            rvalid  <= '0;
            rdata   <= '0;
            rd_pend <= 1'b0;
            rd_ch   <= '0;
        end else begin
            gnt     <= found ? NCH'(1) << win : '0;
            rvalid  <= rd_pend ? NCH'(1) << rd_ch : '0;
            rd_pend <= found & ~we[win];
            if (rd_pend)
                rdata <= mem_q;
            if (found) begin
                rd_ch <= win;
                ptr   <= (win == PW'(NCH - 1)) ? '0 : win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nes_vram_arbiter.sv
// tb_nes_vram_arbiter: scoreboard bench with a behavioural arbitration/memory model
module tb_nes_vram_arbiter;
    localparam int NCH = 3;
    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int LW  = AW + 1;
    localparam int PG  = 2 ** (AW - 1);
`ifdef NES_MIRROR_EN
    localparam bit MIR = 1'b1;
`else
    localparam bit MIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        mirror = 2'b00;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    we = '0;
    logic [NCH*LW-1:0] addr = '0;
    logic [NCH*DW-1:0] wdata = '0;
    logic [NCH-1:0]    gnt, rvalid;
    logic [DW-1:0]     rdata;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        int            ch;
        logic [DW-1:0] d;
    } rd_t;

    int            gq[$];
    rd_t           rq[$];
    logic [DW-1:0] mem_m [2**AW];
    int            mptr = 0;

    nes_vram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .mirror (mirror),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        chk_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t", n, got, exp, $time);
    endtask

    // Logical address -> physical word: four logical pages folded onto two physical banks.
    function automatic int phys_m(logic [LW-1:0] l, logic [1:0] m);
        int page = int'(l) / PG;
        int off  = int'(l) % PG;
        int bank;
        if (!MIR) return int'(l) % (2 ** AW);
        if (m == 2'b00)      bank = page / 2;
        else if (m == 2'b01) bank = page % 2;
        else if (m == 2'b10) bank = 0;
        else                 bank = 1;
        return bank * PG + off;
    endfunction

    // Reference model: observes the inputs at each edge and predicts gnt/rvalid/rdata.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mptr = 0;
            gq.delete();
            rq.delete();
        end else begin
            int w, p, c;
            logic [LW-1:0] l;
            w = -1;
            for (int k = 0; k < NCH; k++) begin
                c = (mptr + k) % NCH;
                if (w < 0 && req[c]) w = c;
            end
            if (w >= 0) begin
                l = addr[w*LW +: LW];
                p = phys_m(l, mirror);
                gq.push_back(w);
                if (we[w]) mem_m[p] = wdata[w*DW +: DW];
                else rq.push_back('{w, mem_m[p]});
                mptr = (w + 1) % NCH;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a gnt or rvalid.
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            if (gnt != 0) begin
                if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
                else chk("gnt_ch", 32'(gnt), 32'd1 << gq.pop_front());
            end
            if (gq.size() != 0) begin
                chk("gnt_missing", 32'(gq.size()), 32'd0);
                gq.delete();
            end
            if (rvalid != 0) begin
                if (rq.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                else begin
                    rd_t e;
                    e = rq.pop_front();
                    chk("rvalid_ch", 32'(rvalid), 32'd1 << e.ch);
                    chk("rdata", 32'(rdata), 32'(e.d));
                end
            end
            if (rq.size() > 1) begin
                chk("rvalid_missing", 32'(rq.size()), 32'd1);
                void'(rq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        req = req & ~gnt;
    endtask

    task automatic access(int ch, logic w, logic [LW-1:0] l, logic [DW-1:0] d);
        req[ch] = 1'b1;
        we[ch] = w;
        addr[ch*LW +: LW] = l;
        wdata[ch*DW +: DW] = d;
        for (int n = 0; n < 4 * NCH && req[ch]; n++) tick();
        chk("access_done", 32'(req[ch]), 32'd0);
        req[ch] = 1'b0;
    endtask

    task automatic rd_chk(string n, int ch, logic [LW-1:0] l, logic [DW-1:0] exp);
        access(ch, 1'b0, l, '0);
        tick();
        chk({n, "_rvalid"}, 32'(rvalid), 32'd1 << ch);
        chk({n, "_rdata"}, 32'(rdata), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        req = '1;
        we  = '1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("first_gnt", 32'(gnt), 32'd1);
        for (int n = 0; n < 10 && req != 0; n++) tick();
        chk("init_drain", 32'(req), 32'd0);

        for (int i = 0; i < 2 ** AW; i++)
            access(0, 1'b1, {i[AW-1], i[AW-1], i[AW-2:0]}, '0);

        mirror = 2'b01;
        access(1, 1'b1, 12'h400, 8'hA5);
        rd_chk("vert", 1, 12'hC00, 8'hA5);

        mirror = 2'b00;
        access(0, 1'b1, 12'h005, 8'h3C);
        rd_chk("horiz_405", 0, 12'h405, MIR ? 8'h3C : 8'h00);
        rd_chk("horiz_805", 0, 12'h805, MIR ? 8'h00 : 8'h3C);

        access(0, 1'b1, 12'h010, 8'h11);
        access(1, 1'b1, 12'h020, 8'h22);
        access(2, 1'b1, 12'h030, 8'h77);
        we[1:0] = 2'b00;
        addr[0 +: LW]  = 12'h010;
        addr[LW +: LW] = 12'h020;
        req[1:0] = 2'b11;
        tick();
        chk("pipe_gnt0", 32'(gnt), 32'd1);
        tick();
        chk("pipe_rv0", 32'(rvalid), 32'd1);
        chk("pipe_d0", 32'(rdata), 32'h11);
        tick();
        chk("pipe_rv1", 32'(rvalid), 32'd2);
        chk("pipe_d1", 32'(rdata), 32'h22);

        access(2, 1'b1, 12'h031, 8'h55);
        we  = '0;
        req = '1;
        for (int i = 0; i < 2 * NCH; i++) begin
            @(posedge clk);
            #2;
            chk("rr_order", 32'(gnt), 32'd1 << (i % NCH));
        end
        req = '0;
        repeat (3) tick();

        access(1, 1'b0, 12'h010, '0);
        reset_n = 1'b0;
        #1;
        chk("rstmid_gnt", 32'(gnt), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("rstmid_rvalid", 32'(rvalid), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        chk("rstmid_rvalid_rel", 32'(rvalid), 32'd0);
        req = '1;
        tick();
        chk("rstmid_ptr", 32'(gnt), 32'd1);
        for (int n = 0; n < 10 && req != 0; n++) tick();
        repeat (2) tick();

        for (int c = 0; c < 600; c++) begin
            tick();
            if ($urandom_range(0, 15) == 0) mirror = 2'($urandom);
            for (int i = 0; i < NCH; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    we[i] = 1'($urandom);
                    addr[i*LW +: LW]  = LW'($urandom);
                    wdata[i*DW +: DW] = DW'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        for (int n = 0; n < 40 && req != 0; n++) tick();
        chk("rand_drain", 32'(req), 32'd0);
        req = '0;
        repeat (3) tick();
        chk("gq_empty", 32'(gq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
